multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, max cycles waiting for mem_ready in any wait state (0 = no timeout).
REQ-002 SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port opcode  input  7  instruction opcode from instruction register, sampled in DECODE.
REQ-005 SHALL have port mem_ready  input  1  memory access complete this cycle.
REQ-006 SHALL have port zero  input  1  ALU zero flag.
REQ-007 SHALL have ports pc_write, ir_write, adr_src, mem_read, mem_write, reg_write  output  1 each  datapath enables/selects.
REQ-008 SHALL have ports alu_src_a, alu_src_b, result_src  output  2 each  datapath mux selects.
REQ-009 SHALL have port alu_op  output  2  to ALU control decoder: 00 add, 01 subtract (compare), 10 decode funct3/funct7.
REQ-010 SHALL have port illegal  output  1  fault flag; port state_o  output  4  current state code.

Function
REQ-011 SHALL implement FSM with codes FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, BEQ=8, FAULT=9; state_o equals current code.
REQ-012 SHALL drive outputs combinationally from state (plus mem_ready/zero where stated); every output not listed for a state SHALL be 0.
REQ-013 FETCH: mem_read=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10; ir_write=pc_write=mem_ready; next DECODE when mem_ready=1, else stay.
REQ-014 DECODE: alu_src_a=01, alu_src_b=01, alu_op=00; next by opcode: 0000011 or 0100011 -> MEMADR, 0110011 -> EXECR, 1100011 -> BEQ, any other -> FAULT.
REQ-015 MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00; next MEMREAD if latched opcode is 0000011, else MEMWRITE.
REQ-016 SHALL latch opcode at DECODE exit; later states SHALL use the latched value, not live opcode.
REQ-017 MEMREAD: adr_src=1, mem_read=1, result_src=00; next MEMWB on mem_ready, else stay.
REQ-018 MEMWB: result_src=01, reg_write=1; next FETCH.
REQ-019 MEMWRITE: adr_src=1, mem_write=1 held until mem_ready; next FETCH on mem_ready, else stay.
REQ-020 EXECR: alu_src_a=10, alu_src_b=00, alu_op=10; next ALUWB. ALUWB: result_src=00, reg_write=1; next FETCH.
REQ-021 BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=zero; next FETCH.
REQ-022 FAULT: illegal=1, all other outputs 0; SHALL stay in FAULT until reset.
REQ-023 Wait counter SHALL clear on every state change and increment each cycle in FETCH/MEMREAD/MEMWRITE with mem_ready=0.
REQ-024 When MEM_TIMEOUT>0 and counter reaches MEM_TIMEOUT with mem_ready=0, next state SHALL be FAULT; mem_ready=1 on that same cycle SHALL take normal transition.
REQ-025 Latency with mem_ready=1 throughout: R-type 4 cycles, load 5, store 4, beq 3.
REQ-026 Cycle counts SHALL be independent of zero except pc_write in BEQ.

Reset
REQ-027 rst_n=0 at a rising edge SHALL force state FETCH, wait counter 0, latched opcode 0, from any state including FAULT and mid-wait.
REQ-028 During and after reset outputs SHALL equal FETCH values: mem_read=1, alu_src_b=10, result_src=10, illegal=0, pc_write=ir_write=mem_ready.

Verification
REQ-029 Hold rst_n=0 two cycles in state 7, mem_ready=0 -> state_o=0, mem_read=1, reg_write=0, illegal=0.
REQ-030 opcode=0110011, mem_ready=1 -> state_o 0,1,6,7,0; alu_op=10 only in 6; reg_write=1 only in 7.
REQ-031 opcode=0000011, mem_ready low 3 cycles in MEMREAD -> state_o 0,1,2,3,3,3,3,4,0; reg_write=1, result_src=01 in 4.
REQ-032 opcode=1100011, zero=1 -> pc_write=1, alu_op=01 in state 8; repeat zero=0 -> pc_write=0; both return to 0.
REQ-033 opcode=1111111 -> state 1 then 9, illegal=1 held 10 cycles with mem_ready toggling; rst_n=0 -> state 0.
REQ-034 MEM_TIMEOUT=4, mem_ready=0 in FETCH -> state 9 after 4 wait cycles; with mem_ready=1 on 4th cycle -> state 1.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle RISC-V control FSM: fetch/decode/execute sequencing,
// memory wait handling with an optional timeout into a sticky fault.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       zero,
  output logic       pc_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] alu_op,
  output logic       illegal,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_BEQ      = 4'd8,
    S_FAULT    = 4'd9
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam int CW  = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam int LIM = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] LIM_C = CW'(LIM);

  state_t          state_q, state_d;
  logic [6:0]      op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            in_wait;
  logic            timeout;
  state_t          cur;

  assign in_wait = (state_q == S_FETCH) ||
                   (state_q == S_MEMREAD) ||
                   (state_q == S_MEMWRITE);
  assign timeout = (MEM_TIMEOUT > 0) && (cnt_q == LIM_C);

  // Next state, opcode latch and memory wait counter.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    unique case (state_q)
      S_FETCH: begin
        if (mem_ready)    state_d = S_DECODE;
        else if (timeout) state_d = S_FAULT;
      end
      S_DECODE: begin
        op_d = opcode;
        unique case (1'b1)
          (opcode == OP_LOAD),
          (opcode == OP_STORE):  state_d = S_MEMADR;
          (opcode == OP_RTYPE):  state_d = S_EXECR;
          (opcode == OP_BRANCH): state_d = S_BEQ;
          default:               state_d = S_FAULT;
        endcase
      end
      S_MEMADR:
        state_d = (op_q == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: begin
        if (mem_ready)    state_d = S_MEMWB;
        else if (timeout) state_d = S_FAULT;
      end
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWRITE: begin
        if (mem_ready)    state_d = S_FETCH;
        else if (timeout) state_d = S_FAULT;
      end
      S_EXECR:  state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BEQ:    state_d = S_FETCH;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_FAULT;
    endcase
    if (state_d != state_q)        cnt_d = '0;
    else if (in_wait && !mem_ready) cnt_d = cnt_q + CW'(1);
    else                            cnt_d = cnt_q;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset shows FETCH outputs even before the clock edge lands.
  assign cur     = rst_n ? state_q : S_FETCH;
  assign state_o = state_q;

  // Datapath controls decoded from the current state.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    alu_op     = 2'b00;
    illegal    = 1'b0;
    unique case (cur)
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        adr_src  = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_write  = zero;
      end
      S_FAULT: illegal = 1'b1;
      default: illegal = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios
// plus a randomized run against an instruction-path reference model.
module tb_multicycle_control;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam int         TO  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, mem_ready, zero;
  logic [6:0] opcode;

  logic       pc_write, ir_write, adr_src, mem_read, mem_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
  logic       illegal;
  logic [3:0] state_o;

  logic       pcw4, irw4, adr4, mrd4, mwr4, rw4;
  logic [1:0] asa4, asb4, rs4, aop4;
  logic       ill4;
  logic [3:0] st4;

  int errors = 0;
  int checks = 0;

  multicycle_control #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode),
    .mem_ready(mem_ready), .zero(zero),
    .pc_write(pc_write), .ir_write(ir_write), .adr_src(adr_src),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .alu_op(alu_op),
    .illegal(illegal), .state_o(state_o)
  );

  multicycle_control #(.MEM_TIMEOUT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode),
    .mem_ready(mem_ready), .zero(zero),
    .pc_write(pcw4), .ir_write(irw4), .adr_src(adr4),
    .mem_read(mrd4), .mem_write(mwr4), .reg_write(rw4),
    .alu_src_a(asa4), .alu_src_b(asb4),
    .result_src(rs4), .alu_op(aop4),
    .illegal(ill4), .state_o(st4)
  );

  wire [14:0] act = {pc_write, ir_write, adr_src, mem_read, mem_write,
                     reg_write, alu_src_a, alu_src_b, result_src,
                     alu_op, illegal};

  // Output table written straight from the per-state control listing.
  function automatic logic [14:0] exp_out(int st, bit mr, bit z, bit rn);
    logic pcw, irw, adr, mrd, mwr, rw, ill;
    logic [1:0] asa, asb, rs, aop;
    pcw = 0; irw = 0; adr = 0; mrd = 0; mwr = 0; rw = 0; ill = 0;
    asa = 0; asb = 0; rs = 0; aop = 0;
    if (!rn) st = 0;
    case (st)
      0: begin mrd = 1; asb = 2; rs = 2; irw = mr; pcw = mr; end
      1: begin asa = 1; asb = 1; end
      2: begin asa = 2; asb = 1; end
      3: begin adr = 1; mrd = 1; end
      4: begin rs = 1; rw = 1; end
      5: begin adr = 1; mwr = 1; end
      6: begin asa = 2; aop = 2; end
      7: rw = 1;
      8: begin asa = 2; aop = 1; pcw = z; end
      9: ill = 1;
      default: ;
    endcase
    return {pcw, irw, adr, mrd, mwr, rw, asa, asb, rs, aop, ill};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0; mem_ready = 0; zero = 0; opcode = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (state_o !== 4'd0 || mem_read !== 1'b1 || ir_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: state=%0d mem_read=%b ir_write=%b want 0 1 0",
               state_o, mem_read, ir_write);
    end
    opcode = RT; mem_ready = 1;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (state_o !== 4'd7) begin
      errors++;
      $display("FAIL reach_aluwb: state=%0d want 7", state_o);
    end
    rst_n = 0; mem_ready = 0;
    @(negedge clk);
    checks++;
    if (mem_read !== 1'b1 || reg_write !== 1'b0 || alu_src_b !== 2'b10) begin
      errors++;
      $display("FAIL reset_during: mem_read=%b reg_write=%b asb=%b want 1 0 10",
               mem_read, reg_write, alu_src_b);
    end
    repeat (2) tick();
    @(negedge clk);
    checks++;
    if (state_o !== 4'd0 || mem_read !== 1'b1 || reg_write !== 1'b0 ||
        illegal !== 1'b0 || pc_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: state=%0d mrd=%b rw=%b ill=%b pcw=%b want 0 1 0 0 0",
               state_o, mem_read, reg_write, illegal, pc_write);
    end
    #1 rst_n = 1;
  endtask

  task automatic test_rtype();
    int ex[5] = '{0, 1, 6, 7, 0};
    do_reset();
    opcode = RT; mem_ready = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (state_o !== 4'(ex[i]) ||
          alu_op !== ((ex[i] == 6) ? 2'b10 : 2'b00) ||
          reg_write !== (ex[i] == 7)) begin
        errors++;
        $display("FAIL rtype[%0d]: state=%0d alu_op=%b rw=%b want state %0d",
                 i, state_o, alu_op, reg_write, ex[i]);
      end
      tick();
    end
  endtask

  task automatic test_load_wait();
    int ex[9] = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
    bit mr[9] = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      mem_ready = mr[i];
      opcode = (i <= 1) ? LW : SW;
      @(negedge clk);
      checks++;
      if (state_o !== 4'(ex[i]) ||
          (ex[i] == 4 && (reg_write !== 1'b1 || result_src !== 2'b01)) ||
          (ex[i] == 3 && (mem_read !== 1'b1 || adr_src !== 1'b1))) begin
        errors++;
        $display("FAIL load[%0d]: state=%0d rw=%b rs=%b want state %0d",
                 i, state_o, reg_write, result_src, ex[i]);
      end
      tick();
    end
  endtask

  task automatic test_latency();
    logic [6:0] ops[4] = '{RT, LW, SW, BQ};
    int lat[4] = '{4, 5, 4, 3};
    for (int k = 0; k < 4; k++) begin
      int n;
      do_reset();
      opcode = ops[k]; mem_ready = 1; zero = k[0];
      n = 0;
      do begin
        tick();
        n++;
      end while (state_o !== 4'd0 && n < 20);
      checks++;
      if (n !== lat[k]) begin
        errors++;
        $display("FAIL latency op=%b: cycles=%0d want %0d", ops[k], n, lat[k]);
      end
    end
  endtask

  task automatic test_beq();
    for (int k = 0; k < 2; k++) begin
      bit z;
      z = (k == 0);
      do_reset();
      opcode = BQ; zero = z; mem_ready = 1;
      repeat (2) tick();
      @(negedge clk);
      checks++;
      if (state_o !== 4'd8 || pc_write !== z || alu_op !== 2'b01) begin
        errors++;
        $display("FAIL beq z=%b: state=%0d pcw=%b alu_op=%b want 8 %b 01",
                 z, state_o, pc_write, alu_op, z);
      end
      tick();
      @(negedge clk);
      checks++;
      if (state_o !== 4'd0) begin
        errors++;
        $display("FAIL beq_ret z=%b: state=%0d want 0", z, state_o);
      end
    end
  endtask

  task automatic test_illegal();
    do_reset();
    opcode = 7'h7F; mem_ready = 1;
    tick();
    @(negedge clk);
    checks++;
    if (state_o !== 4'd1) begin
      errors++;
      $display("FAIL illegal_dec: state=%0d want 1", state_o);
    end
    tick();
    for (int i = 0; i < 10; i++) begin
      mem_ready = i[0];
      opcode = RT;
      @(negedge clk);
      checks++;
      if (state_o !== 4'd9 || illegal !== 1'b1 || mem_read !== 1'b0 ||
          pc_write !== 1'b0 || ir_write !== 1'b0) begin
        errors++;
        $display("FAIL fault_hold[%0d]: state=%0d ill=%b mrd=%b pcw=%b want 9 1 0 0",
                 i, state_o, illegal, mem_read, pc_write);
      end
      tick();
    end
    rst_n = 0;
    tick();
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (state_o !== 4'd0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL fault_reset: state=%0d ill=%b want 0 0", state_o, illegal);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    opcode = RT; mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (st4 !== 4'd0) begin
        errors++;
        $display("FAIL to4_wait[%0d]: state=%0d want 0", i, st4);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (st4 !== 4'd9 || ill4 !== 1'b1 || state_o !== 4'd0) begin
      errors++;
      $display("FAIL to4_fault: st4=%0d ill4=%b st16=%0d want 9 1 0",
               st4, ill4, state_o);
    end
    do_reset();
    mem_ready = 0;
    repeat (3) tick();
    mem_ready = 1;
    tick();
    @(negedge clk);
    checks++;
    if (st4 !== 4'd1) begin
      errors++;
      $display("FAIL to4_ready: state=%0d want 1", st4);
    end
    do_reset();
    mem_ready = 0;
    repeat (15) tick();
    @(negedge clk);
    checks++;
    if (state_o !== 4'd0) begin
      errors++;
      $display("FAIL to16_wait: state=%0d want 0", state_o);
    end
    tick();
    @(negedge clk);
    checks++;
    if (state_o !== 4'd9) begin
      errors++;
      $display("FAIL to16_fault: state=%0d want 9", state_o);
    end
  endtask

  task automatic test_random();
    int mst, mw, r;
    int path[$];
    do_reset();
    mst = 0; mw = 0;
    path.delete();
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      mem_ready = ($urandom_range(0, 3) != 0);
      zero = $urandom_range(0, 1);
      r = $urandom_range(0, 19);
      if (r < 5)       opcode = LW;
      else if (r < 10) opcode = SW;
      else if (r < 14) opcode = RT;
      else if (r < 19) opcode = BQ;
      else             opcode = 7'($urandom);
      @(negedge clk);
      checks++;
      if (state_o !== 4'(mst) ||
          act !== exp_out(mst, mem_ready, zero, rst_n)) begin
        errors++;
        $display("FAIL random[%0d]: state=%0d outs=%h want state %0d outs %h",
                 c, state_o, act, mst,
                 exp_out(mst, mem_ready, zero, rst_n));
      end
      @(posedge clk);
      if (!rst_n) begin
        mst = 0; mw = 0;
        path.delete();
      end else begin
        int nxt;
        nxt = mst;
        if (mst == 9) begin
          nxt = 9;
        end else if ((mst == 0 || mst == 3 || mst == 5) && !mem_ready) begin
          mw++;
          if (mw == TO) nxt = 9;
        end else if (mst == 1) begin
          path.delete();
          if (opcode == LW)      path = '{2, 3, 4};
          else if (opcode == SW) path = '{2, 5};
          else if (opcode == RT) path = '{6, 7};
          else if (opcode == BQ) path = '{8};
          else                   path = '{9};
          nxt = path.pop_front();
        end else if (mst == 0) begin
          nxt = 1;
        end else begin
          nxt = (path.size() > 0) ? path.pop_front() : 0;
        end
        if (nxt != mst) mw = 0;
        mst = nxt;
      end
      #1;
    end
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0; mem_ready = 0; zero = 0; opcode = '0;
    test_reset();
    test_rtype();
    test_load_wait();
    test_latency();
    test_beq();
    test_illegal();
    test_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
